// File: rtl/jump_resolver_n.sv
// jump_resolver_n: front-end jump resolver for an N-wide fetch group.
//
// Each cycle the fetch group is scanned for its first (lowest-index) jump.
// Slots younger than that jump are killed combinationally. An immediate jump
// produces a registered redirect on the next cycle. A register jump requests a
// base value from the register file and holds fetch stalled until the value
// returns, then redirects.
//
// Instruction format (16 bits per slot, slot k at fetch_instr[16k+15:16k]):
//   [15:12] == 4'hF      jump
//   [0] == 0             immediate jump, offset = sext([11:2])
//   [0] == 1             register jump,  offset = sext([7:2]), reg = [11:8]
//
// Optional feature macro: JH_TIMEOUT_EN
//   When defined, WAIT_BASE aborts after TIMEOUT cycles without a response,
//   pulsing timeout_err. When undefined, WAIT_BASE waits indefinitely and
//   timeout_err is tied low.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   fetch_valid     fetch group valid this cycle
//   fetch_pc        PC of slot 0
//   fetch_instr     FETCH_WIDTH packed 16-bit instructions
//   flush           backend squash (synchronous, highest priority)
//   base_rsp_valid  register base value valid
//   base_rsp_data   register base value
//   base_req_valid  base request, held while waiting
//   base_req_reg    register index requested
//   slot_kill_mask  1 = invalidate slot (combinational)
//   redirect_valid  one-cycle redirect strobe
//   redirect_pc     redirect target (qualify with redirect_valid)
//   stall           hold fetch
//   timeout_err     one-cycle pulse on base timeout

module jump_resolver_n #(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_valid,
    input  logic [ADDR_W-1:0]         fetch_pc,
    input  logic [FETCH_WIDTH*16-1:0] fetch_instr,
    input  logic                      flush,
    input  logic                      base_rsp_valid,
    input  logic [ADDR_W-1:0]         base_rsp_data,
    output logic                      base_req_valid,
    output logic [3:0]                base_req_reg,
    output logic [FETCH_WIDTH-1:0]    slot_kill_mask,
    output logic                      redirect_valid,
    output logic [ADDR_W-1:0]         redirect_pc,
    output logic                      stall,
    output logic                      timeout_err
);

    localparam int unsigned IW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitBase,
        StRedirect
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] off_q;

    // Winner selection
    logic                   win_found;
    logic [IW-1:0]          win_idx;
    logic [15:0]            win_instr;
    logic [FETCH_WIDTH-1:0] kill_idle;
    logic                   win_is_reg;
    logic [ADDR_W-1:0]      imm_target;
    logic [ADDR_W-1:0]      reg_off;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_instr = '0;
        kill_idle = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            // A slot is killed when an older slot already holds the winner.
            kill_idle[k] = win_found;
            if (!win_found && fetch_instr[16*k+12 +: 4] == 4'hF) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
                win_instr = fetch_instr[16*k +: 16];
            end
        end
    end

    assign win_is_reg = win_instr[0];
    // Size casts of signed operands sign-extend; sums wrap modulo 2^ADDR_W.
    assign imm_target = fetch_pc + ADDR_W'(win_idx) + ADDR_W'(1)
                      + ADDR_W'($signed(win_instr[11:2]));
    assign reg_off    = ADDR_W'($signed(win_instr[7:2]));

    always_comb begin
        slot_kill_mask = '0;
        unique case (state_q)
            StIdle:  slot_kill_mask = fetch_valid ? kill_idle : '0;
            default: slot_kill_mask = '1;
        endcase
    end

`ifdef JH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            off_q          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stall          <= 1'b0;
            base_req_valid <= 1'b0;
            base_req_reg   <= '0;
`ifdef JH_TIMEOUT_EN
            wait_cnt_q     <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            redirect_valid <= 1'b0;
`ifdef JH_TIMEOUT_EN
            timeout_err    <= 1'b0;
`endif
            if (flush) begin
                // Discard everything pending, including a jump decoded now.
                state_q        <= StIdle;
                stall          <= 1'b0;
                base_req_valid <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (fetch_valid && win_found) begin
                            if (win_is_reg) begin
                                off_q          <= reg_off;
                                base_req_reg   <= win_instr[11:8];
                                base_req_valid <= 1'b1;
                                stall          <= 1'b1;
                                state_q        <= StWaitBase;
`ifdef JH_TIMEOUT_EN
                                wait_cnt_q     <= '0;
`endif
                            end else begin
                                redirect_pc    <= imm_target;
                                redirect_valid <= 1'b1;
                                state_q        <= StRedirect;
                            end
                        end
                    end
                    StWaitBase: begin
                        // A response arriving on the timeout cycle still wins.
                        if (base_rsp_valid) begin
                            redirect_pc    <= base_rsp_data + off_q;
                            redirect_valid <= 1'b1;
                            stall          <= 1'b0;
                            base_req_valid <= 1'b0;
                            state_q        <= StRedirect;
`ifdef JH_TIMEOUT_EN
                        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                            timeout_err    <= 1'b1;
                            stall          <= 1'b0;
                            base_req_valid <= 1'b0;
                            state_q        <= StIdle;
                        end else begin
                            wait_cnt_q     <= wait_cnt_q + CW'(1);
`endif
                        end
                    end
                    StRedirect: begin
                        // Group presented now is wrong-path.
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifndef JH_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/jump_resolver_n.md
Name: jump_resolver_n

Overview:
Parametrised front-end jump resolver for an N-wide fetch group. Each cycle it scans the group for the first jump, kills the younger slots, and issues a registered PC redirect. Immediate jumps are resolved locally. Register-based jumps request a base value from the register file and hold fetch stalled until the value returns. It sits between the fetch unit (PC select / stall) and the register-file read port.

Parameters:
FETCH_WIDTH, 4, instructions per fetch group (1..8)
ADDR_W, 16, PC / address width
TIMEOUT, 64, max WAIT_BASE cycles before abort (used only with JH_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
fetch_valid  input  1  fetch group valid this cycle
fetch_pc  input  ADDR_W  PC of slot 0
fetch_instr  input  FETCH_WIDTH*16  slot k at bits [16k+15:16k]
flush  input  1  backend squash, synchronous
base_rsp_valid  input  1  register base value valid
base_rsp_data  input  ADDR_W  register base value
base_req_valid  output  1  base request, level, held in WAIT_BASE
base_req_reg  output  4  register index requested
slot_kill_mask  output  FETCH_WIDTH  1 = invalidate slot (combinational)
redirect_valid  output  1  one-cycle redirect strobe to PC select
redirect_pc  output  ADDR_W  redirect target
stall  output  1  hold fetch
timeout_err  output  1  one-cycle pulse on base timeout

Behaviour:
- Decode per slot: jump = instr[15:12]==4'hF.
  - Immediate when instr[0]==0; offset = sext(instr[11:2]), 10 bits.
  - Register when instr[0]==1; offset = sext(instr[7:2]), 6 bits; reg = instr[11:8].
- Winner = lowest-index jump slot j. Younger jumps in the same group are ignored.
- Immediate target = fetch_pc + j + 1 + offset. Register target = base_rsp_data + offset. All sums wrap modulo 2^ADDR_W.
- FSM states: IDLE, WAIT_BASE, REDIRECT.
- IDLE, fetch_valid=1, winner j exists:
  - slot_kill_mask bits >j = 1 in the same cycle.
  - Immediate winner: latch target, go to REDIRECT.
  - Register winner: latch offset and reg, go to WAIT_BASE.
- IDLE, no jump or fetch_valid=0: slot_kill_mask=0, state stays IDLE.
- WAIT_BASE:
  - stall=1, base_req_valid=1, base_req_reg = latched reg; incoming fetch groups are ignored.
  - On base_rsp_valid: latch target, go to REDIRECT.
- REDIRECT (exactly 1 cycle): redirect_valid=1, redirect_pc = latched target, stall=0. The fetch group presented this cycle is wrong-path and ignored. Next state is IDLE.
- Latency:
  - Immediate jump in cycle t gives redirect_valid at t+1.
  - Register jump detected at t gives stall/base_req_valid from t+1.
  - base_rsp_valid at cycle r gives redirect_valid at r+1.
- slot_kill_mask is all ones in WAIT_BASE and REDIRECT.
- base_rsp_valid outside WAIT_BASE is ignored.
- flush has highest priority. Next state is IDLE, and redirect_valid, stall and base_req_valid deassert the next cycle. A pending register jump is discarded, and a late response is ignored. A jump decoded in the same cycle as flush is discarded.
- Reset: state=IDLE. redirect_valid, redirect_pc, stall, base_req_valid, base_req_reg and timeout_err are all 0. Internal latches are 0. Reset mid-WAIT_BASE aborts with no redirect.
- redirect_pc holds its last value when redirect_valid=0; consumers qualify it with redirect_valid.

Optional Feature:
JH_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entry to WAIT_BASE and increments each WAIT_BASE cycle.
  - When it reaches TIMEOUT with no base_rsp_valid, timeout_err pulses for 1 cycle and the FSM returns to IDLE with no redirect; stall drops.
  - base_rsp_valid in the same cycle as the timeout wins: normal redirect, no error.
- Not defined: WAIT_BASE waits indefinitely; timeout_err is tied 0; the counter is absent.

Test Plan:
1. FETCH_WIDTH=4, fetch_pc=0x0100, slot2=0xF00C, other slots non-jump -> same cycle kill mask 4'b1000; next cycle redirect_valid=1, redirect_pc=0x0106; group in that cycle ignored.
2. Wrap and negative offsets:
   - fetch_pc=0xFFFE, slot3=0xF010 -> redirect_pc=0x0006.
   - fetch_pc=0x0000, slot0=0xFFFC -> redirect_pc=0x0000, kill 4'b1110.
3. Register jump: slot1=0xF309 -> next cycle stall=1, base_req_valid=1, base_req_reg=3, kill 4'b1100 in detect cycle. Five cycles later base_rsp_valid, data 0x2000 -> next cycle redirect_pc=0x2002, stall=0.
4. Priority: slot1 register jump and slot2 immediate jump in the same group -> WAIT_BASE entered, no immediate redirect, kill 4'b1100.
5. flush during WAIT_BASE, then base_rsp_valid 2 cycles later -> stall=0 and base_req_valid=0 after flush, no redirect_valid ever.
6. JH_TIMEOUT_EN, TIMEOUT=8, register jump with no response -> timeout_err pulses once after 8 WAIT_BASE cycles, stall=0, no redirect; without the macro, stall stays 1 for 100+ cycles.
